txc_epl_tx: RTL and testbench

Per-EPL transmit stage between the Transmit Controller and one EPL port; one instance per port (four per egress partition). Buffers packet words from the TXC, checks SOP/EOP framing, and forwards words to the EPL under credit-based flow control. Credits are consumed per word sent and returned by the EPL.

---
 rtl/txc_epl_pkg.sv | 18 +
 rtl/txc_epl_tx_if.sv | 30 +++
 rtl/txc_epl_fifo.sv | 48 ++++
 rtl/txc_epl_tx.sv | 131 +++++++++++++
 tb/tb_txc_epl_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/txc_epl_pkg.sv
// Shared types for the per-EPL transmit stage: the buffered word format and the
// input/output framing FSM state encodings.
package txc_epl_pkg;

  localparam int DATA_W  = 512;
  localparam int BYTES_W = 6;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [BYTES_W-1:0] bytes;
  } txc_epl_word_t;

  typedef enum logic {I_IDLE, I_PKT} in_state_e;
  typedef enum logic {O_IDLE, O_PKT} out_state_e;

endpackage

// File: rtl/txc_epl_tx_if.sv
// TXC-side word bus and EPL-side word/credit bus of one transmit stage.
// slave is the stage itself, master is whoever drives the TXC and EPL sides.
interface txc_epl_tx_if;
  import txc_epl_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   in_sop;
  logic                   in_eop;
  logic [BYTES_W-1:0]     in_bytes;

  logic                   epl_valid;
  logic [DATA_W-1:0]      epl_data;
  logic                   epl_sop;
  logic                   epl_eop;
  logic [BYTES_W-1:0]     epl_bytes;
  logic                   epl_cdt_ret;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_bytes, epl_cdt_ret,
    input  in_ready, epl_valid, epl_data, epl_sop, epl_eop, epl_bytes
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_bytes, epl_cdt_ret,
    output in_ready, epl_valid, epl_data, epl_sop, epl_eop, epl_bytes
  );

endinterface

// File: rtl/txc_epl_fifo.sv
// Synchronous word FIFO with combinational head read. DEPTH must be a power of
// two; pointers carry one extra wrap bit so full and empty are distinguishable.
module txc_epl_fifo
  import txc_epl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          wr_en,
  input  txc_epl_word_t wr_word,
  input  logic          rd_en,
  output txc_epl_word_t rd_word,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  txc_epl_word_t mem [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so stale contents are never observable after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign level   = LW'(wr_ptr_q - rd_ptr_q);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/txc_epl_tx.sv
// Per-EPL transmit stage: SOP/EOP framing filter, input FIFO and credit-gated
// forwarding to the EPL. Define TXC_EPL_TX_STATS_EN to add pkt_cnt/err_cnt.
module txc_epl_tx
  import txc_epl_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int CREDITS = 8,
  localparam int LW      = $clog2(DEPTH + 1),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          arst,
  txc_epl_tx_if.slave   bus,
  input  logic          cfg_enable,
  output logic          err_frame,
  output logic          cdt_ovf,
  output logic [LW-1:0] fifo_level,
  output logic [CW-1:0] cdt_avail
`ifdef TXC_EPL_TX_STATS_EN
  ,
  output logic [31:0]   pkt_cnt,
  output logic [31:0]   err_cnt
`endif
);

  in_state_e     in_state_q;
  out_state_e    out_state_q;
  txc_epl_word_t wr_word;
  txc_epl_word_t head;
  txc_epl_word_t epl_q;
  logic          epl_valid_q;
  logic          err_q;
  logic          full;
  logic          empty;
  logic          hs;
  logic          keep;
  logic          wr_en;
  logic          drop;
  logic          send;
  logic [CW-1:0] cdt_q;
  logic [CW-1:0] cdt_d;
  logic          ovf_q;
  logic          ovf_d;

  // Ready ignores framing: malformed words are handshaken and then discarded.
  assign bus.in_ready = !full && !arst;
  assign hs           = bus.in_valid && bus.in_ready;
  assign keep         = (in_state_q == I_IDLE) ? bus.in_sop : !bus.in_sop;
  assign wr_en        = hs && keep;
  assign drop         = hs && !keep;
  assign wr_word      = '{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop, bytes: bus.in_bytes};

  // An open packet keeps draining even after cfg_enable drops.
  assign send = !empty && (cdt_q != '0) && ((out_state_q == O_PKT) || cfg_enable);

  txc_epl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (wr_en),
    .wr_word (wr_word),
    .rd_en   (send),
    .rd_word (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    cdt_d = cdt_q;
    ovf_d = ovf_q;
    if (bus.epl_cdt_ret && !send) begin
      if (cdt_q == CW'(CREDITS)) ovf_d = 1'b1;
      else                       cdt_d = cdt_q + CW'(1);
    end else if (!bus.epl_cdt_ret && send) begin
      cdt_d = cdt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_IDLE;
      err_q       <= 1'b0;
      epl_valid_q <= 1'b0;
      epl_q       <= '0;
      cdt_q       <= CW'(CREDITS);
      ovf_q       <= 1'b0;
    end else begin
      err_q       <= drop;
      epl_valid_q <= send;
      cdt_q       <= cdt_d;
      ovf_q       <= ovf_d;
      if (wr_en) in_state_q <= bus.in_eop ? I_IDLE : I_PKT;
      if (send) begin
        epl_q <= head;
        if (head.eop)      out_state_q <= O_IDLE;
        else if (head.sop) out_state_q <= O_PKT;
      end
    end
  end

  assign bus.epl_valid = epl_valid_q;
  assign bus.epl_data  = epl_q.data;
  assign bus.epl_sop   = epl_q.sop;
  assign bus.epl_eop   = epl_q.eop;
  assign bus.epl_bytes = epl_q.bytes;
  assign err_frame     = err_q;
  assign cdt_ovf       = ovf_q;
  assign cdt_avail     = cdt_q;

`ifdef TXC_EPL_TX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (send && head.eop) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (drop)             err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_txc_epl_tx.sv
// Bench for txc_epl_tx: queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_txc_epl_tx;
  import txc_epl_pkg::*;

  localparam int DEPTH   = 16;
  localparam int CREDITS = 8;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int CW      = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          cfg_enable = 1'b0;
  logic          err_frame;
  logic          cdt_ovf;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] cdt_avail;
`ifdef TXC_EPL_TX_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [31:0]   err_cnt;
`endif

  txc_epl_tx_if bus ();

  txc_epl_tx #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .arst       (arst),
    .bus        (bus),
    .cfg_enable (cfg_enable),
    .err_frame  (err_frame),
    .cdt_ovf    (cdt_ovf),
    .fifo_level (fifo_level),
    .cdt_avail  (cdt_avail)
`ifdef TXC_EPL_TX_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int seq   = 1;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: words kept by the framing rules queue up in order and
  // leave one per edge whenever credits and the enable rule allow.
  txc_epl_word_t mq[$];
  bit            m_in_pkt, m_out_pkt, m_ovf, m_err, m_valid;
  int            m_cdt;
  txc_epl_word_t m_word;

  task automatic model_step();
    bit hs, snd, keep;
    if (arst) begin
      mq.delete();
      m_in_pkt = 0; m_out_pkt = 0; m_ovf = 0; m_err = 0; m_valid = 0;
      m_cdt = CREDITS;
      return;
    end
    hs  = bus.in_valid && (mq.size() < DEPTH);
    snd = (mq.size() > 0) && (m_cdt > 0) && (m_out_pkt || cfg_enable);
    m_valid = snd;
    if (snd) begin
      m_word = mq.pop_front();
      if (m_word.eop)      m_out_pkt = 0;
      else if (m_word.sop) m_out_pkt = 1;
    end
    if (bus.epl_cdt_ret && !snd && m_cdt == CREDITS) m_ovf = 1;
    else m_cdt = m_cdt + int'(bus.epl_cdt_ret) - int'(snd);
    keep  = m_in_pkt ? !bus.in_sop : bus.in_sop;
    m_err = hs && !keep;
    if (hs && keep) begin
      mq.push_back('{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop, bytes: bus.in_bytes});
      m_in_pkt = !bus.in_eop;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge arst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en && !arst) begin
      check("in_ready",   bus.in_ready,  mq.size() < DEPTH);
      check("fifo_level", fifo_level,    mq.size());
      check("cdt_avail",  cdt_avail,     m_cdt);
      check("cdt_ovf",    cdt_ovf,       m_ovf);
      check("err_frame",  err_frame,     m_err);
      check("epl_valid",  bus.epl_valid, m_valid);
      if (m_valid) begin
        check("epl_data",  bus.epl_data,  m_word.data);
        check("epl_sop",   bus.epl_sop,   m_word.sop);
        check("epl_eop",   bus.epl_eop,   m_word.eop);
        check("epl_bytes", bus.epl_bytes, m_word.bytes);
      end
    end
  end

  task automatic push(input bit sop, input bit eop, input logic [5:0] bytes);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_bytes = bytes;
    bus.in_data  = {16{seq}};
    seq++;
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("push_wait_bound", waited < 500, 1'b1);
    if (waited < 500) @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic ret(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.epl_cdt_ret = 1'b1;
    end
    @(negedge clk);
    bus.epl_cdt_ret = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.in_bytes = '0;   bus.in_data = '0;  bus.epl_cdt_ret = 1'b0;
    #1 arst = 1'b1;
    wait_cyc(3);
    check("rst_in_ready",   bus.in_ready,  1'b0);
    check("rst_epl_valid",  bus.epl_valid, 1'b0);
    check("rst_epl_sop",    bus.epl_sop,   1'b0);
    check("rst_epl_eop",    bus.epl_eop,   1'b0);
    check("rst_epl_data",   bus.epl_data,  0);
    check("rst_epl_bytes",  bus.epl_bytes, 0);
    check("rst_err_frame",  err_frame,     1'b0);
    check("rst_cdt_ovf",    cdt_ovf,       1'b0);
    check("rst_fifo_level", fifo_level,    0);
    check("rst_cdt_avail",  cdt_avail,     8);
    #2 arst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1'b1);
    cfg_enable = 1'b1;

    // Single-word packet: two-cycle latency, one credit consumed.
    push(1'b1, 1'b1, 6'd17);
    @(negedge clk);
    check("sw_not_yet", bus.epl_valid, 1'b0);
    @(negedge clk);
    check("sw_valid", bus.epl_valid, 1'b1);
    check("sw_bytes", bus.epl_bytes, 17);
    check("sw_cdt",   cdt_avail,     7);
    @(negedge clk);
    check("sw_once",  bus.epl_valid, 1'b0);
    ret(1);

    // Ten-word packet against eight credits.
    for (int i = 0; i < 10; i++) push(i == 0, i == 9, 6'd5);
    wait_cyc(6);
    check("p10_stall_cdt",   cdt_avail,  0);
    check("p10_stall_level", fifo_level, 2);
    ret(2);
    wait_cyc(4);
    check("p10_drained", fifo_level, 0);
    ret(8);

    // Framing errors: stray data word in idle, stray sop inside a packet.
    push(1'b0, 1'b0, 6'd0);
    @(negedge clk);
    check("err_idle_pulse", err_frame,  1'b1);
    check("err_idle_level", fifo_level, 0);
    @(negedge clk);
    check("err_idle_once",  err_frame,  1'b0);
    push(1'b1, 1'b0, 6'd1);
    push(1'b1, 1'b0, 6'd2);
    push(1'b0, 1'b1, 6'd3);
    wait_cyc(5);
    check("err_pkt_level", fifo_level, 0);
    check("err_pkt_cdt",   cdt_avail,  6);
    ret(2);

    // Backpressure: no credits returned until the FIFO is full.
    fork
      for (int i = 0; i < 26; i++) push(i == 0, i == 25, 6'd0);
      begin
        wait_cyc(30);
        check("full_level", fifo_level,   16);
        check("full_ready", bus.in_ready, 1'b0);
        check("full_cdt",   cdt_avail,    0);
        ret(18);
      end
    join
    wait_cyc(6);
    check("full_drained", fifo_level, 0);
    check("full_cdt_end", cdt_avail,  0);
    ret(8);

    // cfg_enable dropped mid-packet: current packet drains, next one waits.
    push(1'b1, 1'b0, 6'd1);
    wait_cyc(3);
    cfg_enable = 1'b0;
    push(1'b0, 1'b0, 6'd2);
    push(1'b0, 1'b1, 6'd3);
    push(1'b1, 1'b0, 6'd4);
    push(1'b0, 1'b1, 6'd5);
    wait_cyc(8);
    check("cfg_held_level", fifo_level,    2);
    check("cfg_held_cdt",   cdt_avail,     5);
    check("cfg_held_idle",  bus.epl_valid, 1'b0);
    cfg_enable = 1'b1;
    wait_cyc(5);
    check("cfg_resume_level", fifo_level, 0);
    check("cfg_resume_cdt",   cdt_avail,  3);
    ret(5);

    // Credit overflow is sticky until reset; reset also flushes the FIFO.
    ret(1);
    check("ovf_set",  cdt_ovf,   1'b1);
    check("ovf_cdt",  cdt_avail, 8);
    wait_cyc(3);
    check("ovf_sticky", cdt_ovf, 1'b1);
    cfg_enable = 1'b0;
    push(1'b1, 1'b0, 6'd9);
    @(negedge clk);
    check("mid_pkt_level", fifo_level, 1);
    #2 arst = 1'b1;
    #1;
    check("arst_ovf",   cdt_ovf,      1'b0);
    check("arst_level", fifo_level,   0);
    check("arst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    #2 arst = 1'b0;
    cfg_enable = 1'b1;
    push(1'b1, 1'b1, 6'd33);
    wait_cyc(3);
    check("post_rst_ovf",   cdt_ovf,   1'b0);
    check("post_rst_cdt",   cdt_avail, 7);
    check("post_rst_level", fifo_level, 0);

    wait_cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
